// File: rtl/synapse_current_gen.sv
// Synaptic current generator feeding the LIF neuron's current port.
// Ports: clk, reset (async high), enable, spike_in[N_IN], w_we/w_addr/w_data
// weight write port, current[WIDTH] registered output, sat clip pulse.
module synapse_current_gen #(
    parameter int N_IN        = 4,
    parameter int WIDTH       = 8,
    parameter int DECAY_SHIFT = 2,
    parameter int PRESCALE    = 4,
    parameter int WEIGHT_INIT = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_IN-1:0]         spike_in,
    input  logic                    w_we,
    input  logic [$clog2(N_IN)-1:0] w_addr,
    input  logic [WIDTH-1:0]        w_data,
    output logic [WIDTH-1:0]        current,
    output logic                    sat
);

    localparam int AW = $clog2(N_IN);
    localparam int SW = WIDTH + AW;
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [SW:0]   MAXV    =
        {{(SW + 1 - WIDTH){1'b0}}, {WIDTH{1'b1}}};

    logic [WIDTH-1:0] weight [N_IN];
    logic [CW-1:0]    cnt;
    logic             tick;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] decayed;
    logic [SW-1:0]    add;
    logic [SW:0]      nxt;

    assign tick = enable && (cnt == CNT_MAX);

    always_comb begin
        dec = current >> DECAY_SHIFT;
        // Small currents would otherwise decay by zero and stick forever.
        if (tick && dec == '0 && current != '0)
            dec = WIDTH'(1);
        decayed = tick ? (current - dec) : current;
    end

    // Spikes read the weight array before this edge's write lands,
    // so a same-cycle write never affects the coincident spike.
    always_comb begin
        add = '0;
        for (int i = 0; i < N_IN; i++)
            if (spike_in[i])
                add = add + SW'(weight[i]);
    end

    assign nxt = (SW + 1)'(decayed) + (SW + 1)'(add);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            current <= '0;
            sat     <= 1'b0;
        end else if (enable) begin
            if (nxt > MAXV) begin
                current <= {WIDTH{1'b1}};
                sat     <= 1'b1;
            end else begin
                current <= nxt[WIDTH-1:0];
                sat     <= 1'b0;
            end
        end else begin
            sat <= 1'b0;
        end
    end

    // Weight writes stay live while the integrator is frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++)
                weight[i] <= WIDTH'(WEIGHT_INIT);
        end else if (w_we) begin
            weight[w_addr] <= w_data;
        end
    end

endmodule

// File: tb/tb_synapse_current_gen.sv
// Bench for synapse_current_gen: behavioural model plus
// hand-computed directed checks.
module tb_synapse_current_gen;

    localparam int N_IN   = 4;
    localparam int WIDTH  = 8;
    localparam int DSHIFT = 2;
    localparam int PRE    = 4;
    localparam int WINIT  = 32;
    localparam int MAXC   = 255;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic [N_IN-1:0]  spike_in = '0;
    logic             w_we = 1'b0;
    logic [1:0]       w_addr = '0;
    logic [WIDTH-1:0] w_data = '0;
    logic [WIDTH-1:0] current;
    logic             sat;

    int vectors = 0;
    int miscompares = 0;

    int m_cur;
    int m_sat;
    int m_cnt;
    int m_w [N_IN];

    synapse_current_gen #(
        .N_IN(N_IN), .WIDTH(WIDTH), .DECAY_SHIFT(DSHIFT),
        .PRESCALE(PRE), .WEIGHT_INIT(WINIT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .spike_in(spike_in), .w_we(w_we), .w_addr(w_addr),
        .w_data(w_data), .current(current), .sat(sat)
    );

    always #5 clk = ~clk;

    // Model: integer arithmetic straight from the update rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cur = 0;
            m_sat = 0;
            m_cnt = 0;
            for (int i = 0; i < N_IN; i++) m_w[i] = WINIT;
        end else begin
            if (enable) begin
                int d, sum, nx;
                bit tk;
                tk = (m_cnt == PRE - 1);
                m_cnt = (m_cnt + 1) % PRE;
                d = 0;
                if (tk) begin
                    d = m_cur / (1 << DSHIFT);
                    if (d == 0 && m_cur > 0) d = 1;
                end
                sum = 0;
                for (int i = 0; i < N_IN; i++)
                    if (spike_in[i]) sum += m_w[i];
                nx = m_cur - d + sum;
                m_sat = (nx > MAXC) ? 1 : 0;
                m_cur = (nx > MAXC) ? MAXC : nx;
            end else begin
                m_sat = 0;
            end
            if (w_we) m_w[w_addr] = w_data;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("model_cur", int'(current), m_cur);
            chk("model_sat", int'(sat), m_sat);
        end
    end

    task automatic step(input bit en, input logic [3:0] spk,
                        input bit we, input int addr, input int data);
        enable   = en;
        spike_in = spk;
        w_we     = we;
        w_addr   = 2'(addr);
        w_data   = 8'(data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 4'b0000, 0, 0, 0);
    endtask

    task automatic do_reset;
        @(negedge clk);
        enable   = 1'b0;
        spike_in = '0;
        w_we     = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        chk("rst_cur", int'(current), 0);
        chk("rst_sat", int'(sat), 0);
        reset = 1'b0;
    endtask

    initial begin
        // 1) single spike on line 0
        do_reset();
        step(1, 4'b0001, 0, 0, 0);
        chk("t1_cur", int'(current), 32);
        chk("t1_sat", int'(sat), 0);

        // 2) geometric decay from 128, ticks at edges 4,8,12,16
        do_reset();
        step(1, 4'b1111, 0, 0, 0);
        chk("t2_start", int'(current), 128);
        idle(2);
        chk("t2_hold", int'(current), 128);
        idle(1);
        chk("t2_96", int'(current), 96);
        idle(3);
        chk("t2_hold96", int'(current), 96);
        idle(1);
        chk("t2_72", int'(current), 72);
        idle(4);
        chk("t2_54", int'(current), 54);
        idle(4);
        chk("t2_41", int'(current), 41);

        // 3) decay floor from 3
        do_reset();
        step(1, 4'b0000, 1, 0, 3);
        step(1, 4'b0001, 0, 0, 0);
        chk("t3_3", int'(current), 3);
        idle(2);
        chk("t3_2", int'(current), 2);
        idle(4);
        chk("t3_1", int'(current), 1);
        idle(4);
        chk("t3_0", int'(current), 0);
        idle(4);
        chk("t3_stay0", int'(current), 0);

        // 4) saturation pulse
        do_reset();
        for (int i = 0; i < N_IN; i++) step(1, 4'b0000, 1, i, 255);
        step(1, 4'b1111, 0, 0, 0);
        chk("t4_max", int'(current), 255);
        chk("t4_sat", int'(sat), 1);
        step(1, 4'b0000, 0, 0, 0);
        chk("t4_hold", int'(current), 255);
        chk("t4_sat_off", int'(sat), 0);

        // 5) write/spike collision uses old weight
        do_reset();
        step(1, 4'b0010, 1, 1, 100);
        chk("t5_old", int'(current), 32);
        step(1, 4'b0010, 0, 0, 0);
        chk("t5_new", int'(current), 132);

        // 6) freeze, weight write while frozen, async reset
        do_reset();
        step(1, 4'b0001, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 4'b1111, 0, 0, 0);
        chk("t6_frozen", int'(current), 32);
        chk("t6_frz_sat", int'(sat), 0);
        step(0, 4'b1111, 1, 2, 7);
        idle(2);
        chk("t6_cnt_held", int'(current), 32);
        idle(1);
        chk("t6_tick", int'(current), 24);
        step(1, 4'b0100, 0, 0, 0);
        chk("t6_w7", int'(current), 31);
        step(1, 4'b0000, 0, 0, 0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_async_cur", int'(current), 0);
        chk("t6_async_sat", int'(sat), 0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 4'b0100, 0, 0, 0);
        chk("t6_w_reinit", int'(current), 32);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
